nibble_rx_ctrl: RTL and testbench
=================================

NIBBLE_RX_CTRL -- requirements
Module: nibble_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clock cycles per serial bit period; legal range 4..255.
REQ-002 SHALL define HALF = floor(CLKS_PER_BIT/2), the start-bit centre offset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1; the reset is asynchronous and active-high.
REQ-005 SHALL have port serial_line, input, 1, raw asynchronous serial input, idle-high.
REQ-006 SHALL have port data_read, input, 1, consumer acknowledge of the buffered nibble.
REQ-007 SHALL have port serial_out, output, 1, synchronized line value, wired to the downstream 4-bit MSB-first SR serial_in.
REQ-008 SHALL have port shift_enable, output, 1, one-cycle strobe at each data-bit centre, wired to the SR shift_enable.
REQ-009 SHALL have port load_buffer, output, 1, one-cycle strobe to capture the SR parallel_out into the receive buffer.
REQ-010 SHALL have ports data_ready, overrun_error and framing_error, each output, 1, status flags.

Function
REQ-011 SHALL pass serial_line through a 2-flop synchronizer; serial_out is the second flop output, with a 2-cycle latency.
REQ-012 SHALL define the edge cycle E as the first cycle in IDLE in which serial_out == 0 and the registered previous serial_out == 1.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, STOP and DONE, with a bit timer and a 3-bit bit counter.
REQ-014 IDLE -> START at E, with the timer cleared.
REQ-015 START: at cycle E+HALF, sample serial_out.
- If serial_out == 1 (false start), return to IDLE with no flag change.
- Else go to DATA and clear framing_error.
REQ-016 DATA: for k = 0..3, assert shift_enable exactly during cycle E+HALF+(k+1)*CLKS_PER_BIT; serial_out in that cycle is the bit the SR captures (MSB first).
REQ-017 After the 4th strobe, go to STOP; shift_enable SHALL never be asserted outside the 4 data-bit cycles.
REQ-018 STOP: at cycle S = E+HALF+5*CLKS_PER_BIT, sample serial_out, then go to DONE.
REQ-019 DONE (cycle S+1), stop bit sampled as 1:
- Assert load_buffer for that single cycle.
- Set data_ready.
- Leave framing_error at 0.
REQ-020 DONE (cycle S+1), stop bit sampled as 0:
- Do not assert load_buffer.
- Set framing_error.
- Leave data_ready unchanged.
REQ-021 DONE -> IDLE unconditionally after one cycle; a new edge SHALL be recognized no earlier than cycle S+2 and requires a fresh 1->0 transition.
REQ-022 data_read == 1 SHALL clear data_ready and overrun_error on the next cycle.
REQ-023 If load_buffer fires while data_ready == 1 and data_read == 0, overrun_error SHALL be set and data_ready SHALL remain 1.
REQ-024 If load_buffer and data_read are both asserted in the same cycle, data_ready SHALL remain 1 and overrun_error SHALL be cleared.
REQ-025 framing_error SHALL hold until the next confirmed start bit (REQ-015).
REQ-026 data_read SHALL have no effect on the FSM.
REQ-027 The timer SHALL be $clog2(CLKS_PER_BIT+1) bits wide and SHALL wrap only under FSM control, never free-running.

Reset
REQ-028 While rst == 1, asynchronously:
- FSM = IDLE, with timer and bit counter at 0.
- Both synchronizer flops = 1, so serial_out = 1.
- shift_enable, load_buffer, data_ready, overrun_error and framing_error = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no load_buffer; after release, the block waits for a new 1->0 edge.

Verification (CLKS_PER_BIT = 10, HALF = 5)
REQ-030 Frame 0, bits 1,0,1,1, stop bit 1:
- shift_enable at E+15, E+25, E+35 and E+45, with serial_out = 1,0,1,1.
- load_buffer at E+56.
- data_ready = 1 from E+57.
REQ-031 Line low for 3 cycles then high (glitch):
- serial_out == 1 at E+5.
- FSM back in IDLE with no strobes and no flag change.
REQ-032 Valid frame with stop bit 0:
- No load_buffer.
- framing_error = 1 from E+57.
- The next valid frame clears framing_error at its E+5 confirmation.
REQ-033 Two valid frames with data_read held at 0:
- overrun_error = 1 after the second load_buffer.
- A one-cycle data_read then clears data_ready and overrun_error.
REQ-034 data_read asserted in exactly the load_buffer cycle while data_ready == 1: data_ready stays 1 and overrun_error stays 0.
REQ-035 rst pulsed at E+30 of a frame:
- All outputs 0 and serial_out 1 during reset.
- No load_buffer for that frame.
- The next clean frame is received correctly.

Source files
------------

// File: rtl/nibble_rx_ctrl.sv
// Serial receive controller for a 4-bit MSB-first frame (start, 4 data, stop).
// Drives the external shift register and tracks ready/overrun/framing status.
module nibble_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_line,
  input  logic data_read,
  output logic serial_out,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic overrun_error,
  output logic framing_error
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT + 1);

  localparam logic [TW-1:0] T_CONFIRM  = TW'(HALF - 1);
  localparam logic [TW-1:0] T_BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE_LAST = TW'(CLKS_PER_BIT - 2);
  localparam logic [TW-1:0] T_ZERO     = TW'(0);
  localparam logic [TW-1:0] T_ONE      = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_cnt;
  logic          r_stop_bit;
  logic          r_shift;
  logic          r_load;
  logic          r_data_ready;
  logic          r_overrun;
  logic          r_framing;

  state_t        w_state_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  logic          w_stop_bit_nxt;
  logic          w_shift_nxt;
  logic          w_load_nxt;
  logic          w_data_ready_nxt;
  logic          w_overrun_nxt;
  logic          w_framing_nxt;
  logic          w_edge;
  logic          w_confirm;

  assign w_edge    = r_prev & ~r_sync2;
  assign w_confirm = (r_state == S_START) && (r_timer == T_CONFIRM) && !r_sync2;

  // Two-flop synchronizer plus previous-value flop for edge detection; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_line;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // FSM state, bit timer, bit counter and captured stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= T_ZERO;
      r_bit_cnt  <= 3'd0;
      r_stop_bit <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_bit <= w_stop_bit_nxt;
    end
  end

  // Next-state logic; the timer only advances inside a frame.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_bit_nxt = r_stop_bit;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt   = T_ZERO;
        w_bit_cnt_nxt = 3'd0;
        if (w_edge) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_timer == T_CONFIRM) begin
          w_timer_nxt   = T_ZERO;
          w_bit_cnt_nxt = 3'd0;
          if (r_sync2) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_DATA: begin
        if (r_timer == T_BIT_LAST) begin
          w_timer_nxt = T_ZERO;
          if (r_bit_cnt == 3'd3) begin
            w_state_nxt   = S_STOP;
            w_bit_cnt_nxt = 3'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_STOP: begin
        if (r_timer == T_BIT_LAST) begin
          w_timer_nxt    = T_ZERO;
          w_stop_bit_nxt = r_sync2;
          w_state_nxt    = S_DONE;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      S_DONE: begin
        w_timer_nxt = T_ZERO;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_timer_nxt   = T_ZERO;
        w_bit_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Strobes are decoded one cycle early so they can leave the block from flops.
  always_comb begin
    w_shift_nxt = 1'b0;
    w_load_nxt  = 1'b0;
    case (r_state)
      S_DATA: begin
        w_shift_nxt = (r_timer == T_PRE_LAST);
      end
      S_STOP: begin
        w_load_nxt = (r_timer == T_BIT_LAST) && r_sync2;
      end
      default: begin
        w_shift_nxt = 1'b0;
        w_load_nxt  = 1'b0;
      end
    endcase
  end

  // Status flag next values; a load in the same cycle as a read keeps the nibble ready.
  always_comb begin
    w_data_ready_nxt = r_data_ready;
    w_overrun_nxt    = r_overrun;
    w_framing_nxt    = r_framing;
    if (r_load) begin
      w_data_ready_nxt = 1'b1;
      if (data_read) begin
        w_overrun_nxt = 1'b0;
      end else if (r_data_ready) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_overrun_nxt = r_overrun;
      end
    end else if (data_read) begin
      w_data_ready_nxt = 1'b0;
      w_overrun_nxt    = 1'b0;
    end else begin
      w_data_ready_nxt = r_data_ready;
      w_overrun_nxt    = r_overrun;
    end
    if (w_confirm) begin
      w_framing_nxt = 1'b0;
    end else if ((r_state == S_DONE) && !r_stop_bit) begin
      w_framing_nxt = 1'b1;
    end else begin
      w_framing_nxt = r_framing;
    end
  end

  // Registered strobes and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= 1'b0;
      r_load       <= 1'b0;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
      r_framing    <= 1'b0;
    end else begin
      r_shift      <= w_shift_nxt;
      r_load       <= w_load_nxt;
      r_data_ready <= w_data_ready_nxt;
      r_overrun    <= w_overrun_nxt;
      r_framing    <= w_framing_nxt;
    end
  end

  assign serial_out    = r_sync2;
  assign shift_enable  = r_shift;
  assign load_buffer   = r_load;
  assign data_ready    = r_data_ready;
  assign overrun_error = r_overrun;
  assign framing_error = r_framing;

endmodule

// File: tb/tb_nibble_rx_ctrl.sv
// Directed bench for nibble_rx_ctrl at CLKS_PER_BIT = 10: frame table plus
// hand-written glitch and mid-frame reset sequences.
module tb_nibble_rx_ctrl;

  logic clk;
  logic rst;
  logic serial_line;
  logic data_read;
  logic serial_out;
  logic shift_enable;
  logic load_buffer;
  logic data_ready;
  logic overrun_error;
  logic framing_error;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0] bits;
    logic       stop;
    bit         pre_read;
    bit         rd_at_load;
    logic       fe_e5;
    logic       dr;
    logic       ov;
    logic       fe;
  } vec_t;

  vec_t vecs [7];

  nibble_rx_ctrl #(.CLKS_PER_BIT(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_line   (serial_line),
    .data_read     (data_read),
    .serial_out    (serial_out),
    .shift_enable  (shift_enable),
    .load_buffer   (load_buffer),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level c cycles after the start-bit falling edge was driven.
  function automatic logic line_val(input logic [3:0] bits, input logic stop, input int c);
    int idx;
    if (c < 10) return 1'b0;
    if (c < 50) begin
      idx = 3 - ((c - 10) / 10);
      return bits[idx[1:0]];
    end
    if (c < 60) return stop;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    serial_line = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_frame(input vec_t v);
    int         n_shift;
    int         n_load;
    int         load_e;
    int         spos [4];
    logic [3:0] cap;
    logic       fe5;
    logic       fe6;
    logic       dr57;
    logic       ov57;
    logic       fe57;
    int         e;
    n_shift = 0;
    n_load  = 0;
    load_e  = -1;
    cap     = 4'd0;
    fe5 = 1'bx; fe6 = 1'bx; dr57 = 1'bx; ov57 = 1'bx; fe57 = 1'bx;
    for (int k = 0; k < 4; k++) spos[k] = -1;
    idle(3);
    if (v.pre_read) begin
      data_read = 1'b1;
      tick();
      data_read = 1'b0;
      check("read_clears_ready", int'(data_ready), 0);
      check("read_clears_overrun", int'(overrun_error), 0);
    end
    for (int c = 0; c <= 64; c++) begin
      serial_line = line_val(v.bits, v.stop, c);
      data_read   = 1'b0;
      e = c - 2;
      if (shift_enable) begin
        if (n_shift < 4) spos[n_shift] = e;
        cap = {cap[2:0], serial_out};
        n_shift++;
      end
      if (load_buffer) begin
        n_load++;
        load_e = e;
        if (v.rd_at_load) data_read = 1'b1;
      end
      if (e == 5)  fe5 = framing_error;
      if (e == 6)  fe6 = framing_error;
      if (e == 57) begin
        dr57 = data_ready;
        ov57 = overrun_error;
        fe57 = framing_error;
      end
      tick();
    end
    data_read = 1'b0;
    check("shift_count", n_shift, 4);
    for (int k = 0; k < 4; k++) check("shift_pos", spos[k], 15 + 10 * k);
    check("captured_nibble", int'(cap), int'(v.bits));
    check("load_count", n_load, int'(v.stop));
    if (v.stop) check("load_pos", load_e, 56);
    check("framing_at_e5", int'(fe5), int'(v.fe_e5));
    check("framing_at_e6", int'(fe6), 0);
    check("ready_at_e57", int'(dr57), int'(v.dr));
    check("overrun_at_e57", int'(ov57), int'(v.ov));
    check("framing_at_e57", int'(fe57), int'(v.fe));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_serial_out"}, int'(serial_out), 1);
    check({tag, "_shift"}, int'(shift_enable), 0);
    check({tag, "_load"}, int'(load_buffer), 0);
    check({tag, "_ready"}, int'(data_ready), 0);
    check({tag, "_overrun"}, int'(overrun_error), 0);
    check({tag, "_framing"}, int'(framing_error), 0);
  endtask

  initial begin
    int n_shift;
    int n_load;
    vec_t clean;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    serial_line = 1'b1;
    data_read = 1'b0;

    vecs[0] = '{4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'b1100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    #2;
    check_reset_outputs("por");
    tick();
    tick();
    rst = 1'b0;
    idle(4);
    check_reset_outputs("idle");

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Glitch: low for 3 cycles only; state afterwards is ready=0 overrun=0 framing=1.
    idle(3);
    n_shift = 0;
    n_load = 0;
    for (int c = 0; c <= 25; c++) begin
      serial_line = (c < 3) ? 1'b0 : 1'b1;
      if (c - 2 == 5) check("glitch_serial_at_e5", int'(serial_out), 1);
      if (shift_enable) n_shift++;
      if (load_buffer) n_load++;
      tick();
    end
    check("glitch_shift_count", n_shift, 0);
    check("glitch_load_count", n_load, 0);
    check("glitch_ready", int'(data_ready), 0);
    check("glitch_overrun", int'(overrun_error), 0);
    check("glitch_framing", int'(framing_error), 1);

    // Reset pulsed at E+30 of a 1011 frame; the rest of that frame is high.
    idle(3);
    n_shift = 0;
    n_load = 0;
    for (int c = 0; c <= 64; c++) begin
      serial_line = line_val(4'b1011, 1'b1, c);
      if (c == 32) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
      end
      if (c == 35) rst = 1'b0;
      if (c >= 32 && shift_enable) n_shift++;
      if (load_buffer) n_load++;
      tick();
    end
    check("midreset_shift_after", n_shift, 0);
    check("midreset_load_count", n_load, 0);
    check("midreset_ready", int'(data_ready), 0);
    check("midreset_framing", int'(framing_error), 0);

    clean = '{4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    run_frame(clean);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
